reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 141 ++++++++++++++
 tb/tb_reset_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronizes the master reset, merges reset requests and
// releases NUM_OUT active-low resets in order after a hold period.
module reset_sequencer #(
   parameter int NUM_OUT        = 4,
   parameter int HOLD_CYCLES    = 16,
   parameter int STAGGER_CYCLES = 4
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               SW_REQ,
   input  logic               EXT_REQ_N,
   output logic [NUM_OUT-1:0] RST_OUT_N,
   output logic               BUSY,
   output logic               DONE
);

   localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = $clog2(NUM_OUT + 1);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT - 1);

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RELEASE = 2'd2,
      ST_RUN     = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [1:0]         sync_q;
   logic               rst_sync;
   logic               req;
   logic               release_now;
   logic               last_rel;

   // Sets the single bit selected by idx; an index past the top selects nothing.
   function automatic logic [NUM_OUT-1:0] release_bit(input logic [NUM_OUT-1:0] cur,
                                                      input logic [IDX_W-1:0]   idx);
      logic [NUM_OUT-1:0] nxt;
      nxt = cur;
      for (int k = 0; k < NUM_OUT; k++) begin
         if (idx == IDX_W'(k)) nxt[k] = 1'b1;
      end
      return nxt;
   endfunction

   // Master reset synchronizer: asserts asynchronously, releases after two edges.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) sync_q <= 2'b00;
      else        sync_q <= {sync_q[0], 1'b1};
   end

   assign rst_sync    = sync_q[1];
   assign req         = !rst_sync || SW_REQ || !EXT_REQ_N;
   assign release_now = ((state_q == ST_HOLD)    && (cnt_q == HOLD_LAST)) ||
                        ((state_q == ST_RELEASE) && (cnt_q == STAG_LAST));
   assign last_rel    = (idx_q == IDX_LAST);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_ASSERT;
         cnt_q     <= '0;
         idx_q     <= '0;
         rst_out_q <= '0;
         busy_q    <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         rst_out_q <= rst_out_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (req) begin
         state_d = ST_ASSERT;
      end else begin
         case (state_q)
            ST_ASSERT:  state_d = ST_HOLD;
            ST_HOLD,
            ST_RELEASE: if (release_now) state_d = last_rel ? ST_RUN : ST_RELEASE;
            ST_RUN:     state_d = ST_RUN;
            default:    state_d = ST_ASSERT;
         endcase
      end
   end

   // idx_q is zero throughout HOLD, so the first release shares the stagger path.
   always_comb begin
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      rst_out_d = rst_out_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      if (req) begin
         cnt_d     = '0;
         idx_d     = '0;
         rst_out_d = '0;
         busy_d    = 1'b1;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               cnt_d = '0;
               idx_d = '0;
            end
            ST_HOLD,
            ST_RELEASE: begin
               if (release_now) begin
                  cnt_d     = '0;
                  idx_d     = idx_q + IDX_W'(1);
                  rst_out_d = release_bit(rst_out_q, idx_q);
                  if (last_rel) begin
                     busy_d = 1'b0;
                     done_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign RST_OUT_N = rst_out_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default instance plus a NUM_OUT=1/HOLD=1/STAGGER=1
// instance, both checked against a time-since-e0 reference model.
module tb_reset_sequencer;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b1;
   logic       SW_REQ = 1'b0;
   logic       EXT_REQ_N = 1'b1;
   logic [3:0] a_out;
   logic       a_busy, a_done;
   logic [0:0] b_out;
   logic       b_busy, b_done;

   int errors = 0;
   int checks = 0;

   reset_sequencer #(.NUM_OUT(4), .HOLD_CYCLES(16), .STAGGER_CYCLES(4)) dut_a (
      .CLK(CLK), .RST_N(RST_N), .SW_REQ(SW_REQ), .EXT_REQ_N(EXT_REQ_N),
      .RST_OUT_N(a_out), .BUSY(a_busy), .DONE(a_done));

   reset_sequencer #(.NUM_OUT(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1)) dut_b (
      .CLK(CLK), .RST_N(RST_N), .SW_REQ(SW_REQ), .EXT_REQ_N(EXT_REQ_N),
      .RST_OUT_N(b_out), .BUSY(b_busy), .DONE(b_done));

   always #5 CLK = ~CLK;

   // Reference model: m_t counts edges since e0 (-1 while a request holds things down).
   int m_sync = 0;
   int m_t = -1;

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_sync = 0;
         m_t    = -1;
      end else begin
         if ((m_sync < 2) || SW_REQ || !EXT_REQ_N) m_t = -1;
         else if (m_t < 0)                          m_t = 0;
         else if (m_t < 100000)                     m_t = m_t + 1;
         if (m_sync < 2) m_sync = m_sync + 1;
      end
   end

   // Returns {busy, done, rst_out[7:0]} for a given time since e0.
   function automatic logic [9:0] exp_vec(input int t, input int n, input int h, input int s);
      logic [9:0] v;
      int last;
      v = '0;
      for (int k = 0; k < n; k++) if (t >= h + k * s) v[k] = 1'b1;
      last = h + (n - 1) * s;
      v[9] = !(t >= last);
      v[8] = (t == last);
      return v;
   endfunction

   logic [9:0] got_a, got_b, exp_a, exp_b;
   assign got_a = {a_busy, a_done, 4'b0000, a_out};
   assign got_b = {b_busy, b_done, 7'b0000000, b_out};

   task automatic test_reset();
      #2 RST_N = 1'b0;
      #1;
      checks++;
      if ({a_out, a_busy, a_done} !== 6'b0000_1_0) begin
         errors++; $display("FAIL reset_async_a: got %b expected 000010", {a_out, a_busy, a_done});
      end
      checks++;
      if ({b_out, b_busy, b_done} !== 3'b0_1_0) begin
         errors++; $display("FAIL reset_async_b: got %b expected 010", {b_out, b_busy, b_done});
      end
      for (int i = 0; i < 3; i++) begin
         SW_REQ = i[0];
         @(posedge CLK); #1;
         checks++;
         if ({a_out, a_busy, a_done} !== 6'b0000_1_0) begin
            errors++; $display("FAIL reset_held_a cycle %0d: got %b expected 000010", i, {a_out, a_busy, a_done});
         end
      end
      SW_REQ = 1'b0;
   endtask

   task automatic test_power_on();
      RST_N = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge CLK); #1;
         exp_a = exp_vec(m_t, 4, 16, 4);
         exp_b = exp_vec(m_t, 1, 1, 1);
         checks++;
         if (got_a !== exp_a) begin
            errors++; $display("FAIL power_on_a edge %0d: got %b expected %b", e, got_a, exp_a);
         end
         checks++;
         if (got_b !== exp_b) begin
            errors++; $display("FAIL power_on_b edge %0d: got %b expected %b", e, got_b, exp_b);
         end
         if (e == 18 || e == 19 || e == 23 || e == 27 || e == 31) begin
            logic [3:0] want;
            want = (e == 18) ? 4'b0000 : (e == 19) ? 4'b0001 : (e == 23) ? 4'b0011 :
                   (e == 27) ? 4'b0111 : 4'b1111;
            checks++;
            if (a_out !== want) begin
               errors++; $display("FAIL power_on_pattern edge %0d: got %b expected %b", e, a_out, want);
            end
         end
         if (e == 30 || e == 31 || e == 32) begin
            checks++;
            if ({a_busy, a_done} !== ((e == 30) ? 2'b10 : (e == 31) ? 2'b01 : 2'b00)) begin
               errors++; $display("FAIL power_on_busy_done edge %0d: got %b", e, {a_busy, a_done});
            end
         end
         if (e == 3 || e == 4 || e == 5) begin
            checks++;
            if ({b_out, b_done} !== ((e == 3) ? 2'b00 : (e == 4) ? 2'b11 : 2'b10)) begin
               errors++; $display("FAIL single_out edge %0d: got %b", e, {b_out, b_done});
            end
         end
      end
   endtask

   task automatic test_sw_req();
      SW_REQ = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(posedge CLK); #1;
         checks++;
         if ({a_out, a_busy} !== 5'b0000_1) begin
            errors++; $display("FAIL sw_req_assert cycle %0d: got %b expected 00001", i, {a_out, a_busy});
         end
      end
      SW_REQ = 1'b0;
      for (int f = 1; f <= 40; f++) begin
         @(posedge CLK); #1;
         exp_a = exp_vec(m_t, 4, 16, 4);
         exp_b = exp_vec(m_t, 1, 1, 1);
         checks++;
         if (got_a !== exp_a) begin
            errors++; $display("FAIL sw_req_a edge %0d: got %b expected %b", f, got_a, exp_a);
         end
         checks++;
         if (got_b !== exp_b) begin
            errors++; $display("FAIL sw_req_b edge %0d: got %b expected %b", f, got_b, exp_b);
         end
         if (f == 16 || f == 17) begin
            checks++;
            if (a_out !== ((f == 16) ? 4'b0000 : 4'b0001)) begin
               errors++; $display("FAIL sw_req_restart edge %0d: got %b", f, a_out);
            end
         end
      end
   endtask

   task automatic test_ext_pulse();
      int w;
      SW_REQ = 1'b1;
      @(posedge CLK); #1;
      SW_REQ = 1'b0;
      w = 0;
      while (m_t != 20 && w < 60) begin
         @(posedge CLK); #1;
         w++;
      end
      checks++;
      if (a_out !== 4'b0011) begin
         errors++; $display("FAIL ext_pulse_setup: got %b expected 0011 after %0d edges", a_out, w);
      end
      EXT_REQ_N = 1'b0;
      @(posedge CLK); #1;
      EXT_REQ_N = 1'b1;
      checks++;
      if ({a_out, a_busy} !== 5'b0000_1) begin
         errors++; $display("FAIL ext_pulse_assert: got %b expected 00001", {a_out, a_busy});
      end
      for (int f = 1; f <= 36; f++) begin
         @(posedge CLK); #1;
         exp_a = exp_vec(m_t, 4, 16, 4);
         checks++;
         if (got_a !== exp_a) begin
            errors++; $display("FAIL ext_pulse_a edge %0d: got %b expected %b", f, got_a, exp_a);
         end
         if (f <= 16) begin
            checks++;
            if (a_out !== 4'b0000) begin
               errors++; $display("FAIL ext_pulse_quiet edge %0d: got %b expected 0000", f, a_out);
            end
         end
      end
   endtask

   task automatic test_both_reqs();
      SW_REQ    = 1'b1;
      EXT_REQ_N = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         if (i == 4) EXT_REQ_N = 1'b1;
         @(posedge CLK); #1;
         checks++;
         if ({a_out, b_out} !== 5'b0000_0) begin
            errors++; $display("FAIL both_reqs_held cycle %0d: got %b expected 00000", i, {a_out, b_out});
         end
      end
      SW_REQ = 1'b0;
      for (int f = 1; f <= 34; f++) begin
         @(posedge CLK); #1;
         exp_a = exp_vec(m_t, 4, 16, 4);
         exp_b = exp_vec(m_t, 1, 1, 1);
         checks++;
         if (got_a !== exp_a) begin
            errors++; $display("FAIL both_reqs_a edge %0d: got %b expected %b", f, got_a, exp_a);
         end
         checks++;
         if (got_b !== exp_b) begin
            errors++; $display("FAIL both_reqs_b edge %0d: got %b expected %b", f, got_b, exp_b);
         end
         if (f == 1 || f == 2 || f == 17) begin
            checks++;
            if ({a_out, b_out} !== ((f == 1) ? 5'b0000_0 : (f == 2) ? 5'b0000_1 : 5'b0001_1)) begin
               errors++; $display("FAIL both_reqs_e0 edge %0d: got %b", f, {a_out, b_out});
            end
         end
      end
   endtask

   task automatic test_async_mid();
      int w;
      SW_REQ = 1'b1;
      @(posedge CLK); #1;
      SW_REQ = 1'b0;
      w = 0;
      while (m_t != 22 && w < 60) begin
         @(posedge CLK); #1;
         w++;
      end
      checks++;
      if (a_out !== 4'b0011) begin
         errors++; $display("FAIL async_setup: got %b expected 0011 after %0d edges", a_out, w);
      end
      #2 RST_N = 1'b0;
      #1;
      checks++;
      if ({a_out, a_busy, a_done, b_out, b_busy, b_done} !== 9'b0000_1_0_0_1_0) begin
         errors++; $display("FAIL async_mid_drop: got %b expected 000010010",
                            {a_out, a_busy, a_done, b_out, b_busy, b_done});
      end
      #1 RST_N = 1'b1;
      for (int e = 1; e <= 34; e++) begin
         @(posedge CLK); #1;
         exp_a = exp_vec(m_t, 4, 16, 4);
         exp_b = exp_vec(m_t, 1, 1, 1);
         checks++;
         if (got_a !== exp_a) begin
            errors++; $display("FAIL async_mid_a edge %0d: got %b expected %b", e, got_a, exp_a);
         end
         checks++;
         if (got_b !== exp_b) begin
            errors++; $display("FAIL async_mid_b edge %0d: got %b expected %b", e, got_b, exp_b);
         end
         if (e == 18 || e == 19) begin
            checks++;
            if (a_out !== ((e == 18) ? 4'b0000 : 4'b0001)) begin
               errors++; $display("FAIL async_mid_restart edge %0d: got %b", e, a_out);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 2500; c++) begin
         @(posedge CLK); #1;
         exp_a = exp_vec(m_t, 4, 16, 4);
         exp_b = exp_vec(m_t, 1, 1, 1);
         checks++;
         if (got_a !== exp_a) begin
            errors++; $display("FAIL random_a cycle %0d: got %b expected %b", c, got_a, exp_a);
         end
         checks++;
         if (got_b !== exp_b) begin
            errors++; $display("FAIL random_b cycle %0d: got %b expected %b", c, got_b, exp_b);
         end
         SW_REQ    = ($urandom_range(0, 79) == 0) ? 1'b1 : (SW_REQ && ($urandom_range(0, 2) != 0));
         EXT_REQ_N = ($urandom_range(0, 79) == 0) ? 1'b0 : (EXT_REQ_N || ($urandom_range(0, 1) == 0));
         if ($urandom_range(0, 399) == 0) begin
            #2 RST_N = 1'b0;
            #2 RST_N = 1'b1;
         end
      end
      SW_REQ    = 1'b0;
      EXT_REQ_N = 1'b1;
   endtask

   initial begin
      test_reset();
      test_power_on();
      test_sw_req();
      test_ext_pulse();
      test_both_reqs();
      test_async_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
